rgb_palette_encoder: RTL and testbench
======================================

RGB_PALETTE_ENCODER -- requirements
Module: rgb_palette_encoder

Interface
REQ-001 SHALL have parameter EARLY_EXIT, default 1, meaning that the scan stops at the first exact-match entry.
REQ-002 SHALL have parameter SKIP_TRANSPARENT, default 1, meaning that entry 0 is a candidate only when the input is exactly 12'h000.
REQ-003 SHALL have port Clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: an RGB request is present.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a request.
REQ-007 SHALL have ports red, green, blue, input, 4 bits each: the request colour, 4'h0-4'hF per channel.
REQ-008 SHALL have port out_valid, output, 1 bit: a result is present.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 SHALL have port index, output, 3 bits: the nearest palette index.
REQ-011 SHALL have port exact, output, 1 bit: distance to the chosen entry is 0.
REQ-012 SHALL have port distance, output, 6 bits: distance to the chosen entry.

Function
REQ-013 SHALL hold a fixed 8-entry 12-bit {R,G,B} table: 0=000, 1=0E1, 2=DA9, 3=766, 4=421, 5=B21, 6=080, 7=EEE.
REQ-014 SHALL have three states: IDLE, SCAN and DONE.
REQ-015 SHALL assert in_ready only in IDLE and out_valid only in DONE.
REQ-016 SHALL latch red, green and blue, clear cnt to 0, set best_dist to 6'h3F, set best_idx to 0, and go to SCAN on the edge where in_valid && in_ready.
REQ-017 SHALL, on each edge in SCAN, compute d = |dR|+|dG|+|dB| using the latched colour against entry cnt, as unsigned with 6-bit result (max 45), with no truncation.
REQ-018 SHALL update best_dist and best_idx only when d < best_dist (strict); ties keep the lower index.
REQ-019 SHALL ignore entry 0 in SCAN when SKIP_TRANSPARENT=1 and the latched colour is not 12'h000.
REQ-020 SHALL go to DONE on the edge that evaluates cnt=7, and otherwise increment cnt (3-bit, no wrap is reachable).
REQ-021 SHALL, when EARLY_EXIT=1, go to DONE on the edge where a non-ignored entry gives d==0, with that entry's result.
REQ-022 SHALL have latency from the accept edge to out_valid high of 8 cycles for a full scan, and i+1 cycles for an early exit at entry i.
REQ-023 SHALL hold index, exact and distance stable while out_valid && !out_ready.
REQ-024 SHALL return to IDLE on the edge with out_valid && out_ready, with in_ready high the following cycle; no request is accepted in that same edge.
REQ-025 SHALL ignore changes on red, green, blue and in_valid outside IDLE.
REQ-026 SHALL set exact to (distance==0) and distance to best_dist, both registered.

Reset
REQ-027 SHALL, while Reset is high, immediately force state=IDLE, in_ready=1, out_valid=0, index=0, exact=0, distance=0, cnt=0 and the latched colour to 0.
REQ-028 SHALL discard an in-flight request on reset mid-SCAN or mid-DONE and produce no output for it.
REQ-029 SHALL accept a new request on the first edge after Reset deasserts.

Verification
REQ-030 SHALL cover: EARLY_EXIT=1, input 0E1 -> index=1, exact=1, distance=0, out_valid 2 cycles after accept.
REQ-031 SHALL cover: input FFF -> index=7, exact=0, distance=3, out_valid 8 cycles after accept.
REQ-032 SHALL cover: input 040 -> index=6, distance=4 with SKIP_TRANSPARENT=1, and index=0, distance=4 (tie rule) with SKIP_TRANSPARENT=0.
REQ-033 SHALL cover: input 000 with SKIP_TRANSPARENT=1 -> index=0, exact=1.
REQ-034 SHALL cover: input DA8 with out_ready low for 5 cycles -> index=2, distance=1 held stable, in_ready=0 throughout, IDLE one edge after out_ready rises.
REQ-035 SHALL cover: Reset pulsed at scan cycle 4 -> out_valid never rises for that request, in_ready=1 during reset, and the next request 421 -> index=4, exact=1.

Source files
------------

// File: rtl/rgb_palette_encoder.sv
// rgb_palette_encoder: nearest-colour search over a fixed 8-entry palette, one entry per cycle
module rgb_palette_encoder #(
  parameter bit EARLY_EXIT       = 1'b1,
  parameter bit SKIP_TRANSPARENT = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] red,
  input  logic [3:0] green,
  input  logic [3:0] blue,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] index,
  output logic       exact,
  output logic [5:0] distance
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  localparam logic [11:0] PAL [8] = '{12'h000, 12'h0E1, 12'hDA9, 12'h766,
                                      12'h421, 12'hB21, 12'h080, 12'hEEE};
  state_t      state, state_n;
  logic [11:0] col, entry;
  logic [2:0]  cnt, best_idx, ni;
  logic [5:0]  best_dist, d, nd;
  logic        skip, better, hit, fin;
  function automatic logic [5:0] ad(input logic [3:0] a, input logic [3:0] b);
    return {2'b00, (a > b) ? a - b : b - a};
  endfunction
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  // Distance of the latched colour to the entry under scan and the running best
  always_comb begin
    entry  = PAL[cnt];
    d      = ad(col[11:8], entry[11:8]) + ad(col[7:4], entry[7:4]) + ad(col[3:0], entry[3:0]);
    skip   = SKIP_TRANSPARENT && cnt == 3'd0 && col != 12'h000;
    better = !skip && d < best_dist;
    nd     = better ? d : best_dist;
    ni     = better ? cnt : best_idx;
    hit    = EARLY_EXIT && !skip && d == 6'd0;
    fin    = hit || cnt == 3'd7;
  end
  // Handshake-driven state sequencing
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (in_valid ? SCAN : IDLE)
            : state == SCAN ? (fin ? DONE : SCAN)
            : (out_ready ? IDLE : DONE);
  end
  // State register; reset discards any request in flight
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= state_n;
  // Request capture, scan bookkeeping and result registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      col       <= '0;
      cnt       <= '0;
      best_dist <= '0;
      best_idx  <= '0;
      index     <= '0;
      exact     <= 1'b0;
      distance  <= '0;
    end else if (state == IDLE && in_valid) begin
      col       <= {red, green, blue};
      cnt       <= '0;
      best_dist <= 6'h3F;
      best_idx  <= '0;
    end else if (state == SCAN) begin
      best_dist <= nd;
      best_idx  <= ni;
      cnt       <= fin ? cnt : cnt + 3'd1;
      if (fin) begin
        index    <= ni;
        distance <= nd;
        exact    <= nd == 6'd0;
      end
    end
  end
endmodule

// File: tb/tb_rgb_palette_encoder.sv
// tb_rgb_palette_encoder: directed checks of the palette encoder with both transparency settings
module tb_rgb_palette_encoder;
  logic       Clk = 1'b0, Reset = 1'b1;
  logic       in_valid = 1'b0, in_valid2 = 1'b0, out_ready = 1'b1, out_ready2 = 1'b1;
  logic [3:0] red = '0, green = '0, blue = '0;
  logic       in_ready, out_valid, exact, in_ready2, out_valid2, exact2;
  logic [2:0] index, index2;
  logic [5:0] distance, distance2;
  int         total = 0, fails = 0, lat;
  logic [2:0] hold_idx;
  logic [5:0] hold_dist;
  always #5 Clk = ~Clk;
  rgb_palette_encoder dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .red(red), .green(green), .blue(blue), .out_valid(out_valid),
    .out_ready(out_ready), .index(index), .exact(exact), .distance(distance));
  rgb_palette_encoder #(.EARLY_EXIT(1'b1), .SKIP_TRANSPARENT(1'b0)) dut2 (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .red(red), .green(green), .blue(blue), .out_valid(out_valid2),
    .out_ready(out_ready2), .index(index2), .exact(exact2), .distance(distance2));
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic run(input bit two, input logic [11:0] c, output int l);
    {red, green, blue} = c;
    if (two) in_valid2 = 1'b1; else in_valid = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    in_valid2 = 1'b0;
    l = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge Clk); #1;
      l++;
      if (two ? out_valid2 : out_valid) break;
    end
  endtask
  task automatic step_idle(input string tag);
    @(posedge Clk); #1;
    chk(tag, in_ready, 1);
  endtask
  initial begin
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_index", index, 0);
    chk("rst_exact", exact, 0);
    chk("rst_distance", distance, 0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    run(0, 12'h0E1, lat);
    chk("0E1_lat", lat, 2);
    chk("0E1_index", index, 1);
    chk("0E1_exact", exact, 1);
    chk("0E1_dist", distance, 0);
    step_idle("0E1_idle");
    run(0, 12'hFFF, lat);
    chk("FFF_lat", lat, 8);
    chk("FFF_index", index, 7);
    chk("FFF_exact", exact, 0);
    chk("FFF_dist", distance, 3);
    step_idle("FFF_idle");
    run(0, 12'h040, lat);
    chk("040_lat", lat, 8);
    chk("040_index", index, 6);
    chk("040_dist", distance, 4);
    step_idle("040_idle");
    run(0, 12'h000, lat);
    chk("000_lat", lat, 1);
    chk("000_index", index, 0);
    chk("000_exact", exact, 1);
    step_idle("000_idle");
    out_ready = 1'b0;
    run(0, 12'hDA8, lat);
    chk("DA8_lat", lat, 8);
    chk("DA8_index", index, 2);
    chk("DA8_dist", distance, 1);
    chk("DA8_exact", exact, 0);
    hold_idx = index;
    hold_dist = distance;
    for (int i = 0; i < 5; i++) begin
      {red, green, blue} = 12'h0E1;
      in_valid = 1'b1;
      @(posedge Clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_index", index, 3'd2);
      chk("hold_dist", distance, 6'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge Clk); #1;
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 0);
    chk("release_index_kept", index, hold_idx);
    chk("release_dist_kept", distance, hold_dist);
    {red, green, blue} = 12'hFFF;
    in_valid = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_index", index, 0);
    chk("midrst_distance", distance, 0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #1;
      if (out_valid) lat++;
    end
    chk("midrst_no_output", lat, 0);
    run(0, 12'h421, lat);
    chk("421_lat", lat, 5);
    chk("421_index", index, 4);
    chk("421_exact", exact, 1);
    chk("421_dist", distance, 0);
    step_idle("421_idle");
    run(1, 12'h040, lat);
    chk("noskip_lat", lat, 8);
    chk("noskip_index", index2, 0);
    chk("noskip_dist", distance2, 4);
    chk("noskip_exact", exact2, 0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
